// File: rtl/div_seq.sv
// Purpose: iterative radix-2 restoring divider (DIV/DIVU) for the EX stage, with HI/LO sign fix-up.
// Latency: start accepted in cycle 0, done pulses in cycle WIDTH+3; fixed, including divide-by-zero.
// Backpressure: holds stall_req from the start cycle through SIGN; annul in PREP/RUN/SIGN aborts to IDLE.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic             annul,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_SIGN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operands as sampled with start; a_q is also the remainder on divide-by-zero.
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sdiv_q;

    // Iteration state: quo starts as |a| and shifts quotient bits in from the right.
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   rem;
    logic [CW-1:0]    cnt;
    logic             neg_quo;
    logic             neg_rem;
    logic             zero_div;

    // Trial subtraction: one extra top bit acts as the borrow/sign of the result.
    logic [WIDTH+1:0] trial;
    logic [WIDTH+1:0] diff;

    assign trial = {rem, quo[WIDTH-1]};
    assign diff  = trial - {2'b00, mag_b};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; annul wins over everything except the DONE cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start && !annul) state_nxt = S_PREP;
            S_PREP: state_nxt = annul ? S_IDLE : S_RUN;
            S_RUN: begin
                if (annul) begin
                    state_nxt = S_IDLE;
                end else if (cnt == '0) begin
                    state_nxt = S_SIGN;
                end
            end
            S_SIGN: state_nxt = annul ? S_IDLE : S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs; the start-cycle stall term is combinational so E holds from cycle 0.
    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        stall_req = (state == S_PREP) || (state == S_RUN) || (state == S_SIGN) ||
                    ((state == S_IDLE) && start && !annul);
    end

    // Datapath: operand capture, magnitude prep, restoring iterations and result write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q         <= '0;
            b_q         <= '0;
            sdiv_q      <= 1'b0;
            quo         <= '0;
            mag_b       <= '0;
            rem         <= '0;
            cnt         <= '0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
            zero_div    <= 1'b0;
            result_lo   <= '0;
            result_hi   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !annul) begin
                        a_q    <= a;
                        b_q    <= b;
                        sdiv_q <= signed_div;
                    end
                end
                S_PREP: begin
                    // abs(most-negative) wraps to itself, which is the right unsigned magnitude.
                    quo      <= (sdiv_q && a_q[WIDTH-1]) ? -a_q : a_q;
                    mag_b    <= (sdiv_q && b_q[WIDTH-1]) ? -b_q : b_q;
                    neg_quo  <= sdiv_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    neg_rem  <= sdiv_q && a_q[WIDTH-1];
                    zero_div <= (b_q == '0);
                    rem      <= '0;
                    cnt      <= CW'(WIDTH - 1);
                end
                S_RUN: begin
                    if (!diff[WIDTH+1]) begin
                        rem <= diff[WIDTH:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= trial[WIDTH:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_SIGN: begin
                    // An annul landing in SIGN must leave the architectural results untouched.
                    if (!annul) begin
                        div_by_zero <= zero_div;
                        if (zero_div) begin
                            result_lo <= '1;
                            result_hi <= a_q;
                        end else begin
                            result_lo <= neg_quo ? -quo : quo;
                            result_hi <= neg_rem ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboarded bench for div_seq: directed divides, divide-by-zero, overflow, annul and async reset.
// Stimulus pushes expected results and done cycle; a negedge monitor pops on every done pulse.
// Inputs change #1 after the rising edge; all sampling happens on the falling edge.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic        annul;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        div_by_zero;

    div_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_div  (signed_div),
        .annul       (annul),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .stall_req   (stall_req),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero)
    );

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] last_lo = 32'h0;
    logic [31:0] last_hi = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
                chk("result_lo", {32'h0, result_lo}, {32'h0, e.lo});
                chk("result_hi", {32'h0, result_hi}, {32'h0, e.hi});
                chk("div_by_zero", {63'h0, div_by_zero}, {63'h0, e.dbz});
            end
        end
    end

    function automatic exp_t mk(input logic [31:0] lo, input logic [31:0] hi, input logic dbz,
                                input int c);
        exp_t e;
        e.lo  = lo;
        e.hi  = hi;
        e.dbz = dbz;
        e.cyc = c;
        return e;
    endfunction

    // Full divide: operands scrambled after cycle 0, a stray start poked while busy,
    // stall_req checked every cycle 0..35, then idle checked in cycle 36.
    task automatic do_div(input logic sd, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] elo, input logic [31:0] ehi, input logic edbz);
        @(posedge clk);
        #1;
        start      = 1'b1;
        signed_div = sd;
        a          = av;
        b          = bv;
        sb.push_back(mk(elo, ehi, edbz, cyc + 35));
        for (int k = 0; k <= 35; k++) begin
            @(negedge clk);
            chk($sformatf("stall_c%0d", k), {63'h0, stall_req}, {63'h0, (k <= 34)});
            @(posedge clk);
            #1;
            if (k == 0) begin
                start      = 1'b0;
                a          = ~av;
                b          = bv + 32'd1;
                signed_div = ~sd;
            end
            if (k == 4) start = 1'b1;
            if (k == 5) start = 1'b0;
        end
        @(negedge clk);
        chk("idle_after_done", {63'h0, busy}, 64'd0);
        last_lo = elo;
        last_hi = ehi;
    endtask

    initial begin
        int c0;
        rst        = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        annul      = 1'b0;
        a          = 32'h0;
        b          = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'h0, busy}, 64'd0);
        chk("rst_stall", {63'h0, stall_req}, 64'd0);
        chk("rst_done", {63'h0, done}, 64'd0);
        chk("rst_dbz", {63'h0, div_by_zero}, 64'd0);
        chk("rst_lo", {32'h0, result_lo}, 64'd0);
        chk("rst_hi", {32'h0, result_hi}, 64'd0);
        rst = 1'b1;

        do_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        do_div(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        do_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0);
        do_div(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0);
        do_div(1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1);
        do_div(1'b1, 32'hFFFFFFF8, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF8, 1'b1);
        do_div(1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
        do_div(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 1'b0);
        do_div(1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'h0, 1'b0);

        // Annul in cycle 10, restart in cycle 11, completes in cycle 46.
        @(posedge clk);
        #1;
        start = 1'b1;
        signed_div = 1'b0;
        a = 32'd1000;
        b = 32'd3;
        c0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 32'h0;
        b = 32'h0;
        repeat (9) @(posedge clk);
        #1;
        chk("annul_at_c10", 64'(cyc - c0), 64'd10);
        annul = 1'b1;
        @(posedge clk);
        #1;
        annul = 1'b0;
        start = 1'b1;
        a = 32'd1000;
        b = 32'd3;
        sb.push_back(mk(32'd333, 32'd1, 1'b0, c0 + 46));
        @(negedge clk);
        chk("annul_busy_c11", {63'h0, busy}, 64'd0);
        chk("annul_keep_lo", {32'h0, result_lo}, {32'h0, last_lo});
        chk("annul_keep_hi", {32'h0, result_hi}, {32'h0, last_hi});
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(posedge clk);

        // Async reset mid-RUN, between clock edges.
        #1;
        start = 1'b1;
        a = 32'd50;
        b = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_busy", {63'h0, busy}, 64'd0);
        chk("arst_stall", {63'h0, stall_req}, 64'd0);
        chk("arst_done", {63'h0, done}, 64'd0);
        chk("arst_dbz", {63'h0, div_by_zero}, 64'd0);
        chk("arst_lo", {32'h0, result_lo}, 64'd0);
        chk("arst_hi", {32'h0, result_hi}, 64'd0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        do_div(1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 1'b0);

        repeat (3) @(posedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
